mem_req_arbiter: RTL

// Shares the single mem_ctrl command port among NUM_REQ requesters (round-robin).

---
 rtl/mem_req_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing the single mem_ctrl command port among NUM_REQ requesters.
// Optional row-hit priority with a starvation cap is enabled by defining ARB_ROW_HIT_PRIO_EN.
module mem_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int CMD_HOLD   = 8,
  parameter int WR_HOLD    = 4,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_vld,
  input  logic [NUM_REQ-1:0]      req_rdnwr,
  input  logic [NUM_REQ*16-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_rdy,
  output logic [NUM_REQ-1:0]      rsp_vld,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    mc_cmd_n,
  output logic                    mc_rdnwr,
  output logic [15:0]             mc_addr,
  output logic                    mc_data_in_vld,
  output logic [31:0]             mc_data_in,
  input  logic [31:0]             mc_data_out,
  input  logic                    mc_data_out_vld
);

  localparam int MAX_A   = (CMD_HOLD > WR_HOLD) ? CMD_HOLD : WR_HOLD;
  localparam int MAX_CNT = (MAX_A > RD_TIMEOUT) ? MAX_A : RD_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int PTR_W   = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD, RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      owner_q;
  logic [PTR_W-1:0]      winner;
  logic                  accept;
  logic [15:0]           sel_addr;
  logic [31:0]           sel_wdata;
  logic                  sel_rdnwr;
  logic                  rdnwr_nxt;
  logic [NUM_REQ-1:0]    owner_oh;

  logic                  mc_cmd_n_q, mc_rdnwr_q, mc_data_in_vld_q;
  logic [15:0]           mc_addr_q;
  logic [31:0]           mc_data_in_q;
  logic [NUM_REQ-1:0]    rsp_vld_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;

  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [PTR_W-1:0]   start);
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(start) + k) % NUM_REQ;
      if (!found && mask[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
    return pick;
  endfunction

`ifdef ARB_ROW_HIT_PRIO_EN
  logic [3:0]         last_row_q;
  logic               last_row_vld_q;
  logic [2:0]         hit_cnt_q;
  logic [NUM_REQ-1:0] hit_mask;
  logic               use_hit;

  // Requesters hitting the open row win, until four hit grants in a row force plain round-robin.
  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_mask[i] = req_vld[i] && last_row_vld_q && (req_addr[16*i+12 +: 4] == last_row_q);
    end
    use_hit = (|hit_mask) && (hit_cnt_q < 3'd4);
    winner  = use_hit ? rr_pick(hit_mask, ptr_q) : rr_pick(req_vld, ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_row_q     <= '0;
      last_row_vld_q <= 1'b0;
      hit_cnt_q      <= '0;
    end else if (accept) begin
      last_row_q     <= sel_addr[15:12];
      last_row_vld_q <= 1'b1;
      hit_cnt_q      <= use_hit ? hit_cnt_q + 3'd1 : 3'd0;
    end
  end
`else
  always_comb begin
    winner = rr_pick(req_vld, ptr_q);
  end
`endif

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rdnwr = 1'b0;
    owner_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        sel_addr  = req_addr[16*i +: 16];
        sel_wdata = req_wdata[32*i +: 32];
        sel_rdnwr = req_rdnwr[i];
      end
      owner_oh[i] = (owner_q == PTR_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_rdy = '0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_vld) begin
          req_rdy[winner] = 1'b1;
          accept          = 1'b1;
          cnt_d           = '0;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_W'(CMD_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = mc_rdnwr_q ? WAIT_RD : WAIT_WR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_WR: begin
        if (cnt_q == CNT_W'(WR_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RD: begin
        if (mc_data_out_vld || (cnt_q == CNT_W'(RD_TIMEOUT - 1))) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdnwr_nxt = accept ? sel_rdnwr : mc_rdnwr_q;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      ptr_q            <= '0;
      owner_q          <= '0;
      mc_cmd_n_q       <= 1'b1;
      mc_rdnwr_q       <= 1'b0;
      mc_addr_q        <= '0;
      mc_data_in_vld_q <= 1'b0;
      mc_data_in_q     <= '0;
      rsp_vld_q        <= '0;
      rsp_rdata_q      <= '0;
      rsp_err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        owner_q      <= winner;
        mc_rdnwr_q   <= sel_rdnwr;
        mc_addr_q    <= sel_addr;
        mc_data_in_q <= sel_rdnwr ? 32'd0 : sel_wdata;
      end
      mc_cmd_n_q       <= (state_d != ISSUE);
      mc_data_in_vld_q <= ((state_d == ISSUE) && !rdnwr_nxt) || (state_d == WAIT_WR);
      rsp_vld_q        <= (state_d == RESP) ? owner_oh : '0;
      rsp_rdata_q      <= ((state_q == WAIT_RD) && mc_data_out_vld) ? mc_data_out : 32'd0;
      rsp_err_q        <= (state_q == WAIT_RD) && !mc_data_out_vld &&
                          (cnt_q == CNT_W'(RD_TIMEOUT - 1));
      if (state_q == RESP) begin
        ptr_q <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
      end
    end
  end

  assign mc_cmd_n       = mc_cmd_n_q;
  assign mc_rdnwr       = mc_rdnwr_q;
  assign mc_addr        = mc_addr_q;
  assign mc_data_in_vld = mc_data_in_vld_q;
  assign mc_data_in     = mc_data_in_q;
  assign rsp_vld        = rsp_vld_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;

endmodule
